// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter that serialises one byte per frame as
// start bit, 8 data bits LSB first, even/odd parity bit and stop bit.
// A baud counter divides the clock into bit periods of DIVISOR cycles.
module uart_tx_core #(
   parameter int DIVISOR = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       wr_enable,
   input  logic       oddeven,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       baud_tick
);

   localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bitIdx_q, bitIdx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             parity_q, parity_d;
   logic             txOut_q, txOut_d;
   logic             parityBit;
   logic             tick;

   // Even parity makes the total count of ones even; odd parity inverts it.
   assign parityBit = oddeven ? ~(^tx_data) : (^tx_data);

   // The tick marks the final clock of every bit period while a frame runs.
   assign tick = (state_q != IDLE) && (cnt_q == CNT_MAX);

   assign tx_out    = txOut_q;
   assign tx_busy   = (state_q != IDLE);
   assign baud_tick = tick;

   // Next-state logic: accept a byte in IDLE, then step through the frame one
   // bit per tick. The counter free-runs only while a frame is in progress.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitIdx_d = bitIdx_q;
      shreg_d  = shreg_q;
      parity_d = parity_q;

      if (state_q != IDLE) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (wr_enable) begin
               shreg_d  = tx_data;
               parity_d = parityBit;
               bitIdx_d = '0;
               cnt_d    = '0;
               state_d  = START;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               if (bitIdx_q == 3'd7) state_d = PARITY;
               else                  bitIdx_d = bitIdx_q + 3'd1;
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The line level is computed from the upcoming state so that it can be
   // registered and still change on the same edge as the state.
   always_comb begin
      txOut_d = 1'b1;
      unique case (state_d)
         IDLE:    txOut_d = 1'b1;
         START:   txOut_d = 1'b0;
         DATA:    txOut_d = shreg_d[bitIdx_d];
         PARITY:  txOut_d = parity_d;
         STOP:    txOut_d = 1'b1;
         default: txOut_d = 1'b1;
      endcase
   end

   // State registers; reset abandons any partial frame and idles the line high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shreg_q  <= '0;
         parity_q <= 1'b0;
         txOut_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shreg_q  <= shreg_d;
         parity_q <= parity_d;
         txOut_q  <= txOut_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: drives byte requests into uart_tx_core and checks the
// serial line against frames predicted from the byte and parity mode.
module tb_uart_tx_core;

   localparam int DIV = 16;
   localparam int FRAME_CYC = 11 * DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       wr_enable;
   logic       oddeven;
   logic       tx_out;
   logic       tx_busy;
   logic       baud_tick;

   int passCnt = 0;
   int totalCnt = 0;

   logic [10:0] expQ[$];
   int          gapQ[$];
   int          framesStarted = 0;

   logic        active = 1'b0;
   logic        rstPrev = 1'b0;
   logic        seenReset = 1'b0;
   logic        checkIdleNext = 1'b0;
   logic [10:0] curFrame;
   int          cyc = 0;
   int          idleCnt = 0;
   int          idleTickErr = 0;
   int          bitErrCnt = 0;
   int          busyErr = 0;
   int          tickErr = 0;
   int          tickCnt = 0;

   uart_tx_core #(.DIVISOR(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .wr_enable (wr_enable),
      .oddeven   (oddeven),
      .tx_out    (tx_out),
      .tx_busy   (tx_busy),
      .baud_tick (baud_tick)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Records one comparison and reports it when it does not hold.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Line levels of a whole frame, index 0 first on the wire.
   function automatic logic [10:0] refFrame(input logic [7:0] d, input logic odd);
      int   ones;
      logic p;
      ones = $countones(d);
      p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return {1'b1, p, d, 1'b0};
   endfunction

   // Monitor: on each falling edge, follow the frame on the line bit by bit
   // and compare against the oldest predicted frame.
   always @(negedge clk) begin
      if (rstPrev) begin
         seenReset = 1'b1;
         checkOutput("reset idle {tx_out,tx_busy,baud_tick}", {tx_out, tx_busy, baud_tick}, 3'b100);
         active = 1'b0;
         checkIdleNext = 1'b0;
         idleCnt = 0;
      end else if (seenReset) begin
         if (!active) begin
            if (checkIdleNext) begin
               checkOutput("tx_busy low after 11*DIV cycles", tx_busy, 1'b0);
               checkIdleNext = 1'b0;
            end
            if (tx_busy === 1'b1) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected frame start", 1, 0);
                  curFrame = 11'h7FF;
               end else begin
                  curFrame = expQ.pop_front();
               end
               checkOutput("idle baud_tick pulses", idleTickErr, 0);
               gapQ.push_back(idleCnt);
               framesStarted++;
               idleCnt = 0;
               idleTickErr = 0;
               active = 1'b1;
               cyc = 0;
               busyErr = 0;
               tickErr = 0;
               tickCnt = 0;
            end else begin
               idleCnt++;
               if (baud_tick !== 1'b0) idleTickErr++;
            end
         end
         if (active) begin
            if ((cyc % DIV) == 0) bitErrCnt = 0;
            if (tx_out !== curFrame[cyc / DIV]) bitErrCnt++;
            if (tx_busy !== 1'b1) busyErr++;
            if (baud_tick !== ((cyc % DIV) == DIV - 1)) tickErr++;
            if (baud_tick === 1'b1) tickCnt++;
            if ((cyc % DIV) == DIV - 1)
               checkOutput($sformatf("frame %0d bit %0d wrong-level cycles", framesStarted, cyc / DIV),
                           bitErrCnt, 0);
            cyc++;
            if (cyc == FRAME_CYC) begin
               checkOutput("baud_tick pulses per frame", tickCnt, 11);
               checkOutput("misplaced baud_tick cycles", tickErr, 0);
               checkOutput("tx_busy low inside frame cycles", busyErr, 0);
               active = 1'b0;
               checkIdleNext = 1'b1;
            end
         end
      end
      rstPrev = rst;
   end

   // Waits until the core is idle, then requests one frame and predicts it.
   task automatic applyStimulus(input logic [7:0] d, input logic odd);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (tx_busy !== 1'b0 && n < 2 * FRAME_CYC) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2 * FRAME_CYC) checkOutput("timeout waiting for idle before request", 1, 0);
      tx_data = d;
      oddeven = odd;
      wr_enable = 1'b1;
      expQ.push_back(refFrame(d, odd));
      @(posedge clk); #1;
      wr_enable = 1'b0;
   endtask

   // Waits until all predicted frames have been seen on the line.
   task automatic waitDone();
      int n;
      n = 0;
      while ((expQ.size() != 0 || active || tx_busy !== 1'b0) && n < 4 * FRAME_CYC) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 4 * FRAME_CYC) checkOutput("timeout waiting for frames to finish", 1, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int n;
      rst = 1'b1;
      wr_enable = 1'b1;
      tx_data = 8'h5A;
      oddeven = 1'b0;

      // Reset held with a pending request: nothing may start.
      repeat (16) @(posedge clk);
      #1;
      rst = 1'b0;
      wr_enable = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Directed frames: even and odd parity of the same byte, then 8'h01.
      applyStimulus(8'b11011000, 1'b0);
      waitDone();
      applyStimulus(8'b11011000, 1'b1);
      waitDone();
      applyStimulus(8'h01, 1'b0);
      waitDone();

      // Inputs changed mid-frame must not affect the latched byte or parity.
      applyStimulus(8'h3C, 1'b1);
      repeat (3 * DIV) @(posedge clk);
      #1;
      tx_data = 8'hFF;
      oddeven = 1'b0;
      wr_enable = 1'b1;
      @(posedge clk); #1;
      wr_enable = 1'b0;
      repeat (2 * DIV) @(posedge clk);
      #1;
      oddeven = 1'b1;
      waitDone();

      // Back-to-back frames with the request held high.
      gapQ.delete();
      base = framesStarted;
      repeat (3) expQ.push_back(refFrame(8'hA5, 1'b0));
      tx_data = 8'hA5;
      oddeven = 1'b0;
      wr_enable = 1'b1;
      n = 0;
      while (framesStarted < base + 3 && n < 5 * FRAME_CYC) begin
         @(posedge clk); #1;
         n++;
      end
      wr_enable = 1'b0;
      if (n >= 5 * FRAME_CYC) checkOutput("timeout waiting for back-to-back frames", 1, 0);
      waitDone();
      if (gapQ.size() >= 3) begin
         checkOutput("idle cycles between frame 1 and 2", gapQ[1], 1);
         checkOutput("idle cycles between frame 2 and 3", gapQ[2], 1);
      end else begin
         checkOutput("back-to-back frames seen", gapQ.size(), 3);
      end

      // Reset pulse during data bit 3 abandons the frame; a new one follows.
      applyStimulus(8'hC3, 1'b0);
      repeat (4 * DIV + 3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      applyStimulus(8'h96, 1'b1);
      waitDone();

      // Randomised bytes, parity modes and spacing.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
      end
      waitDone();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
